// File: rtl/uart_bus_bridge.sv
// Turns UART command frames (W/R/H/G) into 32-bit mem_* bus cycles and queues response bytes for TX.
// Define BRIDGE_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle cycles.
module uart_bus_bridge #(
    parameter int ADDR_WIDTH = 32
`ifdef BRIDGE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 480000
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    output logic                  mem_rstrb,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rbusy,
    input  logic                  mem_wbusy,
    output logic                  cpu_hold,
    output logic                  overrun
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS_WR,
        S_WR_WAIT,
        S_BUS_RD,
        S_RD_WAIT,
        S_SEND,
        S_ACK
    } state_t;

    localparam logic [7:0] OP_W     = 8'h57;
    localparam logic [7:0] OP_R     = 8'h52;
    localparam logic [7:0] OP_H     = 8'h48;
    localparam logic [7:0] OP_G     = 8'h47;
    localparam logic [7:0] BYTE_ACK = 8'h06;
    localparam logic [7:0] BYTE_NAK = 8'h15;

    state_t                r_state, w_state;
    logic [1:0]            r_cnt, w_cnt;
    logic                  r_is_wr, w_is_wr;
    logic [31:0]           r_abuf, w_abuf;
    logic [31:0]           r_dbuf, w_dbuf;
    logic [7:0]            r_tx_data, w_tx_data;
    logic                  r_tx_valid, w_tx_valid;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [31:0]           r_wdata, w_wdata;
    logic [3:0]            r_wmask, w_wmask;
    logic                  r_rstrb, w_rstrb;
    logic                  r_hold, w_hold;
    logic                  r_overrun, w_overrun;
    logic                  w_rx_busy;
    logic                  w_hs;
    logic                  w_tmo;
    logic [1:0]            w_cnt_inc;

    assign w_rx_busy = !(r_state == S_IDLE || r_state == S_ADDR || r_state == S_DATA);
    assign w_hs      = r_tx_valid && tx_ready;
    assign w_cnt_inc = r_cnt + 2'd1;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_idle;

    // Counts idle cycles since the last byte while a frame is being collected.
    always_ff @(posedge clk) begin
        if (reset || rx_valid) begin
            r_idle <= '0;
        end else if ((r_state == S_ADDR || r_state == S_DATA) && r_idle != TMO_LAST) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign w_tmo = (r_state == S_ADDR || r_state == S_DATA) && !rx_valid && (r_idle == TMO_LAST);
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_wr    <= 1'b0;
            r_abuf     <= '0;
            r_dbuf     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_rstrb    <= 1'b0;
            r_hold     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_is_wr    <= w_is_wr;
            r_abuf     <= w_abuf;
            r_dbuf     <= w_dbuf;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_wmask    <= w_wmask;
            r_rstrb    <= w_rstrb;
            r_hold     <= w_hold;
            r_overrun  <= w_overrun;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_is_wr    = r_is_wr;
        w_abuf     = r_abuf;
        w_dbuf     = r_dbuf;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_wmask    = '0;
        w_rstrb    = 1'b0;
        w_hold     = r_hold;
        w_overrun  = r_overrun | (rx_valid & w_rx_busy);

        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_cnt = '0;
                    case (rx_data)
                        OP_W, OP_R: begin
                            w_is_wr = (rx_data == OP_W);
                            w_state = S_ADDR;
                        end
                        OP_H: begin
                            w_hold     = 1'b1;
                            w_tx_data  = BYTE_ACK;
                            w_tx_valid = 1'b1;
                            w_state    = S_ACK;
                        end
                        OP_G: begin
                            w_hold     = 1'b0;
                            w_tx_data  = BYTE_ACK;
                            w_tx_valid = 1'b1;
                            w_state    = S_ACK;
                        end
                        default: begin
                            w_tx_data  = BYTE_NAK;
                            w_tx_valid = 1'b1;
                            w_state    = S_ACK;
                        end
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    w_abuf[{r_cnt, 3'b000} +: 8] = rx_data;
                    w_cnt = w_cnt_inc;
                    if (r_cnt == 2'd3) begin
                        if (r_is_wr) begin
                            w_state = S_DATA;
                        end else begin
                            // Strobe launches straight from the last address byte for 3-cycle latency.
                            w_addr  = ADDR_WIDTH'({w_abuf[31:2], 2'b00});
                            w_rstrb = 1'b1;
                            w_state = S_BUS_RD;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    w_dbuf[{r_cnt, 3'b000} +: 8] = rx_data;
                    w_cnt = w_cnt_inc;
                    if (r_cnt == 2'd3) begin
                        w_addr  = ADDR_WIDTH'({r_abuf[31:2], 2'b00});
                        w_wdata = w_dbuf;
                        w_wmask = '1;
                        w_state = S_BUS_WR;
                    end
                end
            end
            S_BUS_WR: w_state = S_WR_WAIT;
            S_WR_WAIT: begin
                if (!mem_wbusy) begin
                    w_tx_data  = BYTE_ACK;
                    w_tx_valid = 1'b1;
                    w_state    = S_ACK;
                end
            end
            S_BUS_RD: w_state = S_RD_WAIT;
            S_RD_WAIT: begin
                if (!mem_rbusy) begin
                    w_dbuf     = mem_rdata;
                    w_tx_data  = mem_rdata[7:0];
                    w_tx_valid = 1'b1;
                    w_cnt      = '0;
                    w_state    = S_SEND;
                end
            end
            S_SEND: begin
                if (w_hs) begin
                    if (r_cnt == 2'd3) begin
                        w_tx_valid = 1'b0;
                        w_cnt      = '0;
                        w_state    = S_IDLE;
                    end else begin
                        w_tx_data = r_dbuf[{w_cnt_inc, 3'b000} +: 8];
                        w_cnt     = w_cnt_inc;
                    end
                end
            end
            S_ACK: begin
                if (w_hs) begin
                    w_tx_valid = 1'b0;
                    w_state    = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (w_tmo) begin
            w_cnt   = '0;
            w_state = S_IDLE;
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;
    assign mem_rstrb = r_rstrb;
    assign cpu_hold  = r_hold;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomized frame-level bench for uart_bus_bridge: host-side memory/hold model, bus device and TX sink.
`timescale 1ns/1ps
module tb_uart_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;
    logic        cpu_hold;
    logic        overrun;

    always #5 clk = ~clk;

    uart_bus_bridge #(
        .ADDR_WIDTH(32)
`ifdef BRIDGE_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy),
        .mem_wbusy(mem_wbusy), .cpu_hold(cpu_hold), .overrun(overrun)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Host-side view of memory and bridge state.
    logic [31:0] ref_mem [logic [31:0]];
    bit          ref_hold = 1'b0;
    bit          ref_ovr  = 1'b0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    int unsigned rb_delay = 0;
    int unsigned wb_delay = 0;
    int unsigned rdy_mode = 0;
    bit          lat_chk  = 1'b0;
    time         last_rx_t = 0;

    // Bus device: word memory with programmable busy time.
    logic [31:0] dev_mem [logic [31:0]];
    int unsigned wm_hi = 0;
    int unsigned rs_hi = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];

    initial begin
        int unsigned wb_left;
        int unsigned rb_left;
        bit          rd_pend;
        logic [31:0] rd_val;
        wb_left = 0; rb_left = 0; rd_pend = 1'b0; rd_val = '0;
        mem_rdata = '0; mem_rbusy = 1'b0; mem_wbusy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wb_left = 0; rd_pend = 1'b0; mem_rbusy = 1'b0; mem_wbusy = 1'b0;
            end else begin
                if (mem_wmask != 4'h0) begin
                    wm_hi++;
                    check_eq("wmask_value", mem_wmask, 4'hF);
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wdata);
                    dev_mem[mem_addr] = mem_wdata;
                    wb_left   = wb_delay;
                    mem_wbusy = (wb_left > 0);
                end else begin
                    if (wb_left > 0) wb_left--;
                    mem_wbusy = (wb_left > 0);
                end
                if (mem_rstrb) begin
                    rs_hi++;
                    rd_addr_q.push_back(mem_addr);
                    rd_val    = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : dflt(mem_addr);
                    rb_left   = rb_delay;
                    rd_pend   = 1'b1;
                    mem_rbusy = 1'b1;
                    mem_rdata = $urandom;
                end else if (rd_pend) begin
                    if (rb_left == 0) begin
                        mem_rbusy = 1'b0;
                        mem_rdata = rd_val;
                        rd_pend   = 1'b0;
                    end else begin
                        rb_left--;
                        mem_rdata = $urandom;
                    end
                end
            end
        end
    end

    // TX sink: ready pattern per rdy_mode, captures accepted bytes, checks hold-while-stalled.
    logic [7:0] tx_q[$];
    time        rise_t = 0;

    initial begin
        bit          r;
        bit          prev_stall;
        bit          prev_valid;
        logic [7:0]  prev_data;
        int unsigned stall_cnt;
        prev_stall = 1'b0; prev_valid = 1'b0; prev_data = '0; stall_cnt = 0;
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0; prev_valid = 1'b0; stall_cnt = 0;
            end else begin
                if (prev_stall) check_eq("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
                if (tx_valid && !prev_valid) rise_t = $time;
                case (rdy_mode)
                    0:       r = 1'b1;
                    1:       r = ($urandom_range(0, 1) == 1);
                    default: r = (stall_cnt >= 3);
                endcase
                tx_ready = r;
                if (tx_valid && r) begin
                    tx_q.push_back(tx_data);
                    stall_cnt = 0;
                end else if (tx_valid) begin
                    stall_cnt++;
                end
                prev_stall = tx_valid && !r;
                prev_data  = tx_data;
                prev_valid = tx_valid;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        repeat (gap) @(negedge clk);
        rx_data   = b;
        rx_valid  = 1'b1;
        last_rx_t = $time;
        @(negedge clk);
        rx_valid  = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                             input int unsigned maxgap, input bit inject);
        logic [7:0]  exp_q[$];
        logic [31:0] wa;
        logic [31:0] rv;
        bit          is_w;
        bit          is_r;
        int unsigned tx0, wm0, rs0, wq0, rq0;
        wa   = {a[31:2], 2'b00};
        is_w = (op == 8'h57);
        is_r = (op == 8'h52);
        if (is_w) begin
            ref_mem[wa] = d;
            exp_q.push_back(8'h06);
        end else if (is_r) begin
            rv = ref_rd(wa);
            for (int i = 0; i < 4; i++) exp_q.push_back(rv[8*i +: 8]);
        end else if (op == 8'h48) begin
            ref_hold = 1'b1;
            exp_q.push_back(8'h06);
        end else if (op == 8'h47) begin
            ref_hold = 1'b0;
            exp_q.push_back(8'h06);
        end else begin
            exp_q.push_back(8'h15);
        end
        tx0 = tx_q.size(); wm0 = wm_hi; rs0 = rs_hi;
        wq0 = wr_addr_q.size(); rq0 = rd_addr_q.size();

        send_byte(op, $urandom_range(0, maxgap));
        if (is_w || is_r)
            for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], $urandom_range(0, maxgap));
        if (is_w)
            for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], $urandom_range(0, maxgap));
        if (inject) begin
            for (int i = 0; i < 200 && !tx_valid; i++) @(negedge clk);
            send_byte(8'h57, 0);
            ref_ovr = 1'b1;
        end
        for (int i = 0; i < 400 && tx_q.size() < tx0 + exp_q.size(); i++) @(negedge clk);
        repeat (4) @(negedge clk);

        check_eq("tx_count", tx_q.size() - tx0, exp_q.size());
        for (int i = 0; i < exp_q.size() && tx0 + i < tx_q.size(); i++)
            check_eq("tx_byte", tx_q[tx0 + i], exp_q[i]);
        check_eq("tx_idle", tx_valid, 1'b0);
        check_eq("wmask_pulses", wm_hi - wm0, is_w ? 1 : 0);
        check_eq("rstrb_pulses", rs_hi - rs0, is_r ? 1 : 0);
        if (is_w && wr_addr_q.size() > wq0) begin
            check_eq("wr_addr", wr_addr_q[wq0], wa);
            check_eq("wr_data", wr_data_q[wq0], d);
        end
        if (is_r && rd_addr_q.size() > rq0) check_eq("rd_addr", rd_addr_q[rq0], wa);
        if (lat_chk && !inject && (is_w || is_r))
            check_eq("latency", (rise_t - last_rx_t) / 10, 3);
        check_eq("cpu_hold", cpu_hold, ref_hold);
        check_eq("overrun", overrun, ref_ovr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_valid"}, tx_valid, 1'b0);
        check_eq({tag, "_tx_data"}, tx_data, 8'h00);
        check_eq({tag, "_wmask"}, mem_wmask, 4'h0);
        check_eq({tag, "_rstrb"}, mem_rstrb, 1'b0);
        check_eq({tag, "_addr"}, mem_addr, 32'h0);
        check_eq({tag, "_wdata"}, mem_wdata, 32'h0);
        check_eq({tag, "_hold"}, cpu_hold, 1'b0);
        check_eq({tag, "_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        int unsigned sel;
        int unsigned wm0;
        reset = 1'b1; rx_data = '0; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        rdy_mode = 0; rb_delay = 0; wb_delay = 0; lat_chk = 1'b1;
        run_frame(8'h57, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b0);
        run_frame(8'h52, 32'h0000_0100, 32'h0, 0, 1'b0);
        run_frame(8'h48, 32'h0, 32'h0, 0, 1'b0);
        run_frame(8'h47, 32'h0, 32'h0, 0, 1'b0);
        run_frame(8'h7A, 32'h0, 32'h0, 0, 1'b0);
        run_frame(8'h57, 32'hFFFF_FFFF, 32'h1234_5678, 1, 1'b0);
        run_frame(8'h52, 32'hFFFF_FFFE, 32'h0, 1, 1'b0);

        lat_chk = 1'b0; rb_delay = 5; rdy_mode = 2;
        run_frame(8'h52, 32'h0000_0101, 32'h0, 0, 1'b0);
        rb_delay = 0;
        run_frame(8'h52, 32'h0000_0100, 32'h0, 0, 1'b1);
        run_frame(8'h47, 32'h0, 32'h0, 0, 1'b0);

        rdy_mode = 0;
        run_frame(8'h48, 32'h0, 32'h0, 0, 1'b0);
        wm0 = wm_hi;
        send_byte(8'h57, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        ref_hold = 1'b0;
        ref_ovr  = 1'b0;
        check_eq("partial_no_write", wm_hi - wm0, 0);
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3)      op = 8'h57;
            else if (sel <= 6) op = 8'h52;
            else if (sel == 7) op = 8'h48;
            else if (sel == 8) op = 8'h47;
            else begin
                do op = 8'($urandom); while (op == 8'h57 || op == 8'h52 || op == 8'h48 || op == 8'h47);
            end
            if ($urandom_range(0, 2) != 0) a = 32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            else                           a = $urandom;
            d        = $urandom;
            rb_delay = $urandom_range(0, 3);
            wb_delay = $urandom_range(0, 3);
            rdy_mode = $urandom_range(0, 2);
            lat_chk  = (rb_delay == 0) && (wb_delay == 0);
            run_frame(op, a, d, $urandom_range(0, 2), 1'b0);
        end

`ifdef BRIDGE_TIMEOUT_EN
        rdy_mode = 0; rb_delay = 0; wb_delay = 0; lat_chk = 1'b1;
        begin
            int unsigned tx0;
            tx0 = tx_q.size();
            send_byte(8'h57, 0);
            send_byte(8'h00, 0);
            repeat (20) @(negedge clk);
            check_eq("timeout_no_tx", tx_q.size() - tx0, 0);
            check_eq("timeout_tx_valid", tx_valid, 1'b0);
        end
        run_frame(8'h52, 32'h0000_0100, 32'h0, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
